// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
//
// UART receiver for 8N1 frames (optionally 8E1/8O1). The serial line is
// synchronized into sys_clk and sampled on the 16x oversampling enable from
// the UART clock generator. Each received byte is held in a one-entry output
// buffer with a valid/ready handshake. Framing errors and overruns are
// reported as one-cycle pulses.
//
// Optional feature macro: UART_RX_PARITY_EN
//   Defined   : a parity bit follows the data bits. It is checked against
//               XOR(data) ^ PARITY_ODD, and a mismatch discards the byte and
//               pulses rx_parity_err.
//   Undefined : plain 8N1 receiver with no rx_parity_err port.
//
// Ports
//   sys_clk        in   system clock, the only clock in the block
//   sys_rst        in   synchronous active-high reset
//   uart_rx_clk    in   one-cycle enable at OVERSAMPLE x baud
//   uart_rxd       in   asynchronous serial line, idle high
//   rx_data        out  received byte, stable while rx_data_valid is high
//   rx_data_valid  out  byte available, held until accepted
//   rx_data_ready  in   consumer accepts on rx_data_valid & rx_data_ready
//   rx_frame_err   out  one-cycle pulse when the stop bit is sampled low
//   rx_overrun     out  one-cycle pulse when a byte completes while the
//                       buffer is still full (the new byte is dropped)
//   rx_parity_err  out  one-cycle pulse on parity mismatch (macro only)
//
// FSM states
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | line idle, waiting for a low sample
//   S_START  | counting to mid start bit to confirm it is not a glitch
//   S_DATA   | sampling DATA_BITS data bits at mid bit, LSB first
//   S_PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
//   S_STOP   | sampling the stop bit; byte completes or frame error
//   S_BREAK  | line held low after a frame error, waiting for high
// ---------------------------------------------------------------------------
module uart_rx_core #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int PARITY_ODD  = 0
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 uart_rx_clk,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_data_valid,
    input  logic                 rx_data_ready,
    output logic                 rx_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 rx_overrun,
    output logic                 rx_parity_err
`else
    output logic                 rx_overrun
`endif
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    // Elaboration-time parameter sanity checks.
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $error("uart_rx_core: OVERSAMPLE must be even and >= 8");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("uart_rx_core: SYNC_STAGES must be >= 2");
    end
    if (DATA_BITS < 2) begin : g_bad_data_bits
        $error("uart_rx_core: DATA_BITS must be >= 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_rx_core: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    // -----------------------------------------------------------------------
    // Input synchronizer; resets to the idle (high) line level so that a
    // start bit is only seen after a real high-to-low transition.
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxd_s;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rxd};
        end
    end

    assign rxd_s = sync_q[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // Receive FSM
    // -----------------------------------------------------------------------
    state_t                 state_q,  state_d;
    logic [CNT_W-1:0]       cnt_q,    cnt_d;
    logic [BIT_W-1:0]       bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0]   shift_q,  shift_d;
    logic                   byte_done;
    logic                   frame_err_d;
`ifdef UART_RX_PARITY_EN
    localparam logic PAR_SENSE = (PARITY_ODD != 0);
    logic                   parity_bad_q, parity_bad_d;
    logic                   parity_err_d;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bitcnt_q     <= '0;
            shift_q      <= '0;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= parity_bad_d;
`endif
        end
    end

    // Everything below is gated by uart_rx_clk so the FSM state only moves
    // on oversampling ticks.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        byte_done    = 1'b0;
        frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad_d = parity_bad_q;
        parity_err_d = 1'b0;
`endif
        if (uart_rx_clk) begin
            case (state_q)
                S_IDLE: begin
                    if (!rxd_s) begin
                        state_d = S_START;
                        cnt_d   = '0;
                    end
                end

                S_START: begin
                    if (cnt_q == CNT_MID) begin
                        if (rxd_s) begin
                            // Line went back high before mid start bit.
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d  = S_DATA;
                            cnt_d    = '0;
                            bitcnt_d = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                        if (bitcnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            bitcnt_d = bitcnt_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        // The verdict is held until the stop bit so that a
                        // framing error can take precedence over it.
                        parity_bad_d = (^shift_q) ^ PAR_SENSE ^ rxd_s;
                        state_d      = S_STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif

                S_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (rxd_s) begin
                            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                            if (parity_bad_q) begin
                                parity_err_d = 1'b1;
                            end else begin
                                byte_done = 1'b1;
                            end
`else
                            byte_done = 1'b1;
`endif
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = S_BREAK;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                S_BREAK: begin
                    // One frame error per low period, however long.
                    if (rxd_s) begin
                        state_d = S_IDLE;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output buffer and status pulses, updated every sys_clk
    // -----------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_data       <= '0;
            rx_data_valid <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            rx_parity_err <= 1'b0;
`endif
        end else begin
            rx_frame_err <= frame_err_d;
            rx_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            rx_parity_err <= parity_err_d;
`endif
            if (byte_done) begin
                // A byte accepted in the same cycle frees the buffer.
                if (!rx_data_valid || rx_data_ready) begin
                    rx_data       <= shift_q;
                    rx_data_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_data_valid && rx_data_ready) begin
                rx_data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;

    localparam int OS       = 16;
    localparam int TICK_DIV = 28;

    logic       sys_clk       = 1'b0;
    logic       sys_rst       = 1'b1;
    logic       uart_rx_clk   = 1'b0;
    logic       uart_rxd      = 1'b1;
    logic       rx_data_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_frame_err;
    logic       rx_overrun;
`ifdef UART_RX_PARITY_EN
    logic       rx_parity_err;
`endif

    int checks = 0;
    int errors = 0;

    int         acc_cnt  = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt  = 0;
    int         perr_cnt = 0;
    logic [7:0] acc_data[$];
    int         div_cnt  = 0;

    uart_rx_core dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .uart_rx_clk   (uart_rx_clk),
        .uart_rxd      (uart_rxd),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_data_ready (rx_data_ready),
        .rx_frame_err  (rx_frame_err),
`ifdef UART_RX_PARITY_EN
        .rx_overrun    (rx_overrun),
        .rx_parity_err (rx_parity_err)
`else
        .rx_overrun    (rx_overrun)
`endif
    );

    always #10 sys_clk = ~sys_clk;

    // 16x tick: one sys_clk wide, every TICK_DIV cycles
    always @(posedge sys_clk) begin
        if (div_cnt == TICK_DIV - 1) begin
            div_cnt     <= 0;
            uart_rx_clk <= 1'b1;
        end else begin
            div_cnt     <= div_cnt + 1;
            uart_rx_clk <= 1'b0;
        end
    end

    // Monitor: handshakes and pulse-high cycles, sampled mid-cycle
    always @(negedge sys_clk) begin
        if (rx_data_valid === 1'b1 && rx_data_ready === 1'b1) begin
            acc_cnt++;
            acc_data.push_back(rx_data);
        end
        if (rx_frame_err !== 1'b0) ferr_cnt++;
        if (rx_overrun !== 1'b0) ovr_cnt++;
`ifdef UART_RX_PARITY_EN
        if (rx_parity_err !== 1'b0) perr_cnt++;
`endif
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic wait_ticks(input int n);
        int seen  = 0;
        int guard = 0;
        while (seen < n && guard < n * TICK_DIV * 2 + 10) begin
            @(posedge sys_clk);
            guard++;
            if (uart_rx_clk) seen++;
        end
        #1;
    endtask

    task automatic send_bit(input logic b);
        uart_rxd = b;
        wait_ticks(OS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_ok);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par_ok ? ^d : ~^d);
`endif
        send_bit(stop);
    endtask

    task automatic test_reset;
        sys_rst  = 1'b1;
        uart_rxd = 1'b1;
        repeat (5) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (rx_data_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", rx_data_valid);
        end
        checks++;
        if (rx_data !== 8'h00) begin
            errors++; $display("FAIL reset_data: got %h expected 00", rx_data);
        end
        checks++;
        if (rx_frame_err !== 1'b0) begin
            errors++; $display("FAIL reset_frame_err: got %b expected 0", rx_frame_err);
        end
        checks++;
        if (rx_overrun !== 1'b0) begin
            errors++; $display("FAIL reset_overrun: got %b expected 0", rx_overrun);
        end
        @(posedge sys_clk);
        #1;
        send_bit(1'b1);
        send_bit(1'b1);
    endtask

    task automatic test_back_to_back;
        int a0 = acc_cnt;
        int f0 = ferr_cnt;
        int o0 = ovr_cnt;
        logic [7:0] got;
        send_frame(8'hA5, 1'b1, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b1);
        send_bit(1'b1);
        @(negedge sys_clk);
        checks++;
        if (acc_cnt - a0 !== 2) begin
            errors++; $display("FAIL b2b_count: got %0d expected 2", acc_cnt - a0);
        end
        got = (acc_data.size() > a0) ? acc_data[a0] : 8'hxx;
        checks++;
        if (got !== 8'hA5) begin
            errors++; $display("FAIL b2b_byte0: got %h expected a5", got);
        end
        got = (acc_data.size() > a0 + 1) ? acc_data[a0 + 1] : 8'hxx;
        checks++;
        if (got !== 8'h3C) begin
            errors++; $display("FAIL b2b_byte1: got %h expected 3c", got);
        end
        checks++;
        if (ferr_cnt - f0 !== 0 || ovr_cnt - o0 !== 0) begin
            errors++; $display("FAIL b2b_errors: got ferr %0d ovr %0d expected 0 0", ferr_cnt - f0, ovr_cnt - o0);
        end
        checks++;
        if (rx_data_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_valid_drop: got %b expected 0", rx_data_valid);
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_glitch;
        int a0 = acc_cnt;
        int f0 = ferr_cnt;
        logic [7:0] got;
        uart_rxd = 1'b0;
        wait_ticks(4);
        uart_rxd = 1'b1;
        wait_ticks(OS * 2);
        @(negedge sys_clk);
        checks++;
        if (acc_cnt - a0 !== 0 || rx_data_valid !== 1'b0) begin
            errors++; $display("FAIL glitch_valid: got %0d bytes valid %b expected 0 bytes", acc_cnt - a0, rx_data_valid);
        end
        checks++;
        if (ferr_cnt - f0 !== 0) begin
            errors++; $display("FAIL glitch_frame_err: got %0d expected 0", ferr_cnt - f0);
        end
        @(posedge sys_clk);
        #1;
        send_frame(8'h5A, 1'b1, 1'b1);
        send_bit(1'b1);
        @(negedge sys_clk);
        checks++;
        if (acc_cnt - a0 !== 1) begin
            errors++; $display("FAIL glitch_next_count: got %0d expected 1", acc_cnt - a0);
        end
        got = (acc_data.size() > a0) ? acc_data[a0] : 8'hxx;
        checks++;
        if (got !== 8'h5A) begin
            errors++; $display("FAIL glitch_next_data: got %h expected 5a", got);
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_frame_err;
        int a0 = acc_cnt;
        int f0 = ferr_cnt;
        logic [7:0] got;
        send_frame(8'h3C, 1'b0, 1'b1);
        repeat (20) send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        @(negedge sys_clk);
        checks++;
        if (ferr_cnt - f0 !== 1) begin
            errors++; $display("FAIL ferr_count: got %0d expected 1", ferr_cnt - f0);
        end
        checks++;
        if (acc_cnt - a0 !== 0) begin
            errors++; $display("FAIL ferr_no_valid: got %0d bytes expected 0", acc_cnt - a0);
        end
        @(posedge sys_clk);
        #1;
        send_frame(8'h81, 1'b1, 1'b1);
        send_bit(1'b1);
        @(negedge sys_clk);
        checks++;
        if (acc_cnt - a0 !== 1) begin
            errors++; $display("FAIL ferr_recover_count: got %0d expected 1", acc_cnt - a0);
        end
        got = (acc_data.size() > a0) ? acc_data[a0] : 8'hxx;
        checks++;
        if (got !== 8'h81) begin
            errors++; $display("FAIL ferr_recover_data: got %h expected 81", got);
        end
        checks++;
        if (ferr_cnt - f0 !== 1) begin
            errors++; $display("FAIL ferr_recover_no_err: got %0d expected 1 total", ferr_cnt - f0);
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_overrun;
        int a0 = acc_cnt;
        int o0 = ovr_cnt;
        logic [7:0] got;
        rx_data_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b1);
        send_bit(1'b1);
        @(negedge sys_clk);
        checks++;
        if (rx_data_valid !== 1'b1 || rx_data !== 8'h11) begin
            errors++; $display("FAIL ovr_first_held: got valid %b data %h expected 1 11", rx_data_valid, rx_data);
        end
        @(posedge sys_clk);
        #1;
        send_frame(8'h22, 1'b1, 1'b1);
        send_bit(1'b1);
        @(negedge sys_clk);
        checks++;
        if (ovr_cnt - o0 !== 1) begin
            errors++; $display("FAIL ovr_pulse: got %0d cycles expected 1", ovr_cnt - o0);
        end
        checks++;
        if (rx_data !== 8'h11 || rx_data_valid !== 1'b1) begin
            errors++; $display("FAIL ovr_old_kept: got valid %b data %h expected 1 11", rx_data_valid, rx_data);
        end
        checks++;
        if (acc_cnt - a0 !== 0) begin
            errors++; $display("FAIL ovr_no_accept: got %0d expected 0", acc_cnt - a0);
        end
        @(posedge sys_clk);
        #1 rx_data_ready = 1'b1;
        @(negedge sys_clk);
        @(posedge sys_clk);
        #1;
        checks++;
        if (acc_cnt - a0 !== 1) begin
            errors++; $display("FAIL ovr_accept_count: got %0d expected 1", acc_cnt - a0);
        end
        got = (acc_data.size() > a0) ? acc_data[a0] : 8'hxx;
        checks++;
        if (got !== 8'h11) begin
            errors++; $display("FAIL ovr_accept_data: got %h expected 11", got);
        end
        checks++;
        if (rx_data_valid !== 1'b0) begin
            errors++; $display("FAIL ovr_valid_drop: got %b expected 0", rx_data_valid);
        end
    endtask

    task automatic test_reset_mid;
        int a0, f0, o0;
        logic [7:0] got;
        // start bit and three data bits of 0xFF, then reset mid-DATA
        send_bit(1'b0);
        repeat (3) send_bit(1'b1);
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (rx_data !== 8'h00 || rx_data_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_outputs: got data %h valid %b expected 00 0", rx_data, rx_data_valid);
        end
        checks++;
        if (rx_frame_err !== 1'b0 || rx_overrun !== 1'b0) begin
            errors++; $display("FAIL rstmid_pulses: got ferr %b ovr %b expected 0 0", rx_frame_err, rx_overrun);
        end
        a0 = acc_cnt;
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        @(posedge sys_clk);
        #1;
        repeat (8) send_bit(1'b1);
        @(negedge sys_clk);
        checks++;
        if (acc_cnt - a0 !== 0 || ferr_cnt - f0 !== 0 || ovr_cnt - o0 !== 0) begin
            errors++; $display("FAIL rstmid_rest: got bytes %0d ferr %0d ovr %0d expected 0 0 0", acc_cnt - a0, ferr_cnt - f0, ovr_cnt - o0);
        end
        @(posedge sys_clk);
        #1;
        send_frame(8'h42, 1'b1, 1'b1);
        send_bit(1'b1);
        @(negedge sys_clk);
        checks++;
        if (acc_cnt - a0 !== 1) begin
            errors++; $display("FAIL rstmid_next_count: got %0d expected 1", acc_cnt - a0);
        end
        got = (acc_data.size() > a0) ? acc_data[a0] : 8'hxx;
        checks++;
        if (got !== 8'h42) begin
            errors++; $display("FAIL rstmid_next_data: got %h expected 42", got);
        end
        @(posedge sys_clk);
        #1;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int a0 = acc_cnt;
        int p0 = perr_cnt;
        int f0 = ferr_cnt;
        logic [7:0] got;
        send_frame(8'h07, 1'b1, 1'b1);
        send_bit(1'b1);
        @(negedge sys_clk);
        got = (acc_data.size() > a0) ? acc_data[a0] : 8'hxx;
        checks++;
        if (acc_cnt - a0 !== 1 || got !== 8'h07) begin
            errors++; $display("FAIL parity_good: got %0d bytes data %h expected 1 07", acc_cnt - a0, got);
        end
        checks++;
        if (perr_cnt - p0 !== 0) begin
            errors++; $display("FAIL parity_good_err: got %0d expected 0", perr_cnt - p0);
        end
        @(posedge sys_clk);
        #1;
        send_frame(8'h07, 1'b1, 1'b0);
        send_bit(1'b1);
        @(negedge sys_clk);
        checks++;
        if (perr_cnt - p0 !== 1) begin
            errors++; $display("FAIL parity_bad_pulse: got %0d expected 1", perr_cnt - p0);
        end
        checks++;
        if (acc_cnt - a0 !== 1 || ferr_cnt - f0 !== 0) begin
            errors++; $display("FAIL parity_bad_discard: got bytes %0d ferr %0d expected 1 0", acc_cnt - a0, ferr_cnt - f0);
        end
        @(posedge sys_clk);
        #1;
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
